// File: rtl/mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// mem_stage_pkg : BEOp encodings, control-bus bit positions, FSM states and
//                 the misalignment helper shared by the MEM-stage access block.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_stage_pkg;

  localparam logic [2:0] BEOP_WORD  = 3'b000;
  localparam logic [2:0] BEOP_HALFU = 3'b001;
  localparam logic [2:0] BEOP_HALFS = 3'b010;
  localparam logic [2:0] BEOP_BYTEU = 3'b011;
  localparam logic [2:0] BEOP_BYTES = 3'b100;

  localparam int BEOP_LSB     = 7;
  localparam int MEMREAD_BIT  = 10;
  localparam int MEMWRITE_BIT = 11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  // Encodings 101-111 fall into the word case, so they need word alignment.
  function automatic logic is_misaligned(input logic [2:0] beop, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (beop)
      BEOP_HALFU, BEOP_HALFS: mis = addr_lo[0];
      BEOP_BYTEU, BEOP_BYTES: mis = 1'b0;
      default:                mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_access_if.sv
// ----------------------------------------------------------------------------
// mem_stage_access_if : req/ack data-memory bus between MEM stage and memory.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mem_stage_access_if;
  logic        dm_req_o;
  logic        dm_we_o;
  logic [31:0] dm_addr_o;
  logic [3:0]  dm_be_o;
  logic [31:0] dm_wdata_o;
  logic [31:0] dm_rdata_i;
  logic        dm_ack_i;

  modport master (
    output dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o,
    input  dm_rdata_i, dm_ack_i
  );

  modport slave (
    input  dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o,
    output dm_rdata_i, dm_ack_i
  );
endinterface

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ----------------------------------------------------------------------------
// mem_lane_align : store byte-enable/data lane steering and load extract/extend.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  beop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rt,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [15:0] half;
  logic [7:0]  byte_v;

  always_comb begin
    be        = 4'b1111;
    wdata     = rt;
    load_data = rdata;
    half      = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    byte_v    = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase

    case (beop)
      BEOP_HALFU, BEOP_HALFS: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{rt[15:0]}};
        load_data = {{16{(beop == BEOP_HALFS) & half[15]}}, half};
      end
      BEOP_BYTEU, BEOP_BYTES: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{rt[7:0]}};
        load_data = {{24{(beop == BEOP_BYTES) & byte_v[7]}}, byte_v};
      end
      default: begin
        be        = 4'b1111;
        wdata     = rt;
        load_data = rdata;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage_access.sv
// ----------------------------------------------------------------------------
// mem_stage_access : MEM-stage data-memory access with stall, timeout and
//                    misalignment detection; loads the MEM/WB register.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_stage_access
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] signal_mem_i,
  input  logic [31:0] npc_mem_i,
  input  logic [31:0] alu_out_mem_i,
  input  logic [31:0] rt_mem_i,
  input  logic [31:0] rd_mem_i,
  mem_stage_access_if.master dm,
  output logic        stall_o,
  output logic        mem_err_o,
  output logic [31:0] signal_wb_o,
  output logic [31:0] npc_wb_o,
  output logic [31:0] alu_out_wb_o,
  output logic [31:0] rd_wb_o,
  output logic [31:0] load_data_wb_o
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             req_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;

  logic [2:0]  beop;
  logic        mem_write;
  logic        access;
  logic        misaligned;
  logic        ack_done;
  logic        timed_out;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;

  assign beop       = signal_mem_i[BEOP_LSB +: 3];
  assign mem_write  = signal_mem_i[MEMWRITE_BIT];
  assign access     = signal_mem_i[MEMREAD_BIT] | mem_write;
  assign misaligned = access & is_misaligned(beop, alu_out_mem_i[1:0]);
  assign ack_done   = (state == ST_REQ) & dm.dm_ack_i;
  assign timed_out  = (state == ST_REQ) & ~dm.dm_ack_i & (wait_cnt == CNT_LAST);

  // Gated by rst so an asynchronous reset releases the pipeline immediately.
  assign stall_o = ~rst & (((state == ST_IDLE) & access & ~misaligned) |
                           ((state == ST_REQ) & ~ack_done & ~timed_out));

  assign dm.dm_req_o   = req_q;
  assign dm.dm_we_o    = we_q;
  assign dm.dm_addr_o  = addr_q;
  assign dm.dm_be_o    = be_q;
  assign dm.dm_wdata_o = wdata_q;

  mem_lane_align u_lane (
    .beop      (beop),
    .addr_lo   (alu_out_mem_i[1:0]),
    .rt        (rt_mem_i),
    .rdata     (dm.dm_rdata_i),
    .be        (lane_be),
    .wdata     (lane_wdata),
    .load_data (lane_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      wait_cnt       <= '0;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      be_q           <= '0;
      wdata_q        <= '0;
      mem_err_o      <= 1'b0;
      signal_wb_o    <= '0;
      npc_wb_o       <= '0;
      alu_out_wb_o   <= '0;
      rd_wb_o        <= '0;
      load_data_wb_o <= '0;
    end else begin
      mem_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (access && !misaligned) begin
            state    <= ST_REQ;
            wait_cnt <= '0;
            req_q    <= 1'b1;
            we_q     <= mem_write;
            addr_q   <= {alu_out_mem_i[31:2], 2'b00};
            be_q     <= lane_be;
            wdata_q  <= lane_wdata;
          end else if (misaligned) begin
            mem_err_o      <= 1'b1;
            signal_wb_o    <= '0;
            npc_wb_o       <= '0;
            alu_out_wb_o   <= '0;
            rd_wb_o        <= '0;
            load_data_wb_o <= '0;
          end else begin
            signal_wb_o    <= signal_mem_i;
            npc_wb_o       <= npc_mem_i;
            alu_out_wb_o   <= alu_out_mem_i;
            rd_wb_o        <= rd_mem_i;
            load_data_wb_o <= '0;
          end
        end
        ST_REQ: begin
          if (ack_done) begin
            state          <= ST_IDLE;
            req_q          <= 1'b0;
            signal_wb_o    <= signal_mem_i;
            npc_wb_o       <= npc_mem_i;
            alu_out_wb_o   <= alu_out_mem_i;
            rd_wb_o        <= rd_mem_i;
            load_data_wb_o <= mem_write ? 32'd0 : lane_load;
          end else if (timed_out) begin
            state          <= ST_IDLE;
            req_q          <= 1'b0;
            mem_err_o      <= 1'b1;
            signal_wb_o    <= '0;
            npc_wb_o       <= '0;
            alu_out_wb_o   <= '0;
            rd_wb_o        <= '0;
            load_data_wb_o <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_access.sv
// ----------------------------------------------------------------------------
// tb_mem_stage_access : directed + randomized bench for mem_stage_access.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage_access;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] signal_mem, npc_mem, alu_out_mem, rt_mem, rd_mem;
  logic        stall, mem_err;
  logic [31:0] signal_wb, npc_wb, alu_out_wb, rd_wb, load_data_wb;
  int          total = 0;
  int          bad   = 0;

  mem_stage_access_if dm_if ();

  always #5 clk = ~clk;

  mem_stage_access #(.TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .signal_mem_i   (signal_mem),
    .npc_mem_i      (npc_mem),
    .alu_out_mem_i  (alu_out_mem),
    .rt_mem_i       (rt_mem),
    .rd_mem_i       (rd_mem),
    .dm             (dm_if),
    .stall_o        (stall),
    .mem_err_o      (mem_err),
    .signal_wb_o    (signal_wb),
    .npc_wb_o       (npc_wb),
    .alu_out_wb_o   (alu_out_wb),
    .rd_wb_o        (rd_wb),
    .load_data_wb_o (load_data_wb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: access size in bytes and lane arithmetic.
  function automatic int size_of(input logic [2:0] beop);
    if (beop == 3'd1 || beop == 3'd2) return 2;
    if (beop == 3'd3 || beop == 3'd4) return 1;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] beop, input logic [31:0] addr);
    int s   = size_of(beop);
    int off = int'(addr % 4);
    if (s == 4) return 4'hF;
    return 4'(((1 << s) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] beop, input logic [31:0] rt);
    int s = size_of(beop);
    if (s == 2) return (rt & 32'hFFFF) * 32'h0001_0001;
    if (s == 1) return (rt & 32'hFF) * 32'h0101_0101;
    return rt;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] beop, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int          s = size_of(beop);
    logic [31:0] v;
    v = rdata >> (8 * int'(addr % 4));
    if (s == 2) begin
      v = v & 32'hFFFF;
      if (beop == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
    end else if (s == 1) begin
      v = v & 32'hFF;
      if (beop == 3'd4 && v[7]) v = v | 32'hFFFF_FF00;
    end
    return v;
  endfunction

  // One EX/MEM instruction followed by a non-access filler; called at a negedge.
  // waits = number of wait states before ack; >= TO means never acked.
  task automatic do_op(input string tag, input logic [2:0] beop, input logic rd_en,
                       input logic wr_en, input logic [31:0] addr, input logic [31:0] rt,
                       input logic [31:0] rdata, input int waits);
    logic [31:0] sig, npc, rdf, sig2;
    logic        access, mis;
    bit          done;
    sig = $urandom;
    sig[9:7] = beop;
    sig[10]  = rd_en;
    sig[11]  = wr_en;
    npc = $urandom;
    rdf = $urandom;
    access = rd_en | wr_en;
    mis    = access && ((addr % size_of(beop)) != 0);
    signal_mem = sig; npc_mem = npc; alu_out_mem = addr; rt_mem = rt; rd_mem = rdf;
    #1;
    check({tag, ":stall_idle"}, stall, access && !mis);
    check({tag, ":req_idle"}, dm_if.dm_req_o, 1'b0);
    @(posedge clk); @(negedge clk);
    if (!access || mis) begin
      check({tag, ":err"}, mem_err, mis);
      check({tag, ":sig_wb"}, signal_wb, mis ? 32'd0 : sig);
      check({tag, ":req"}, dm_if.dm_req_o, 1'b0);
      if (!mis) begin
        check({tag, ":npc_wb"}, npc_wb, npc);
        check({tag, ":alu_wb"}, alu_out_wb, addr);
        check({tag, ":rd_wb"}, rd_wb, rdf);
        check({tag, ":ld_wb"}, load_data_wb, 32'd0);
      end
    end else begin
      done = 1'b0;
      for (int k = 0; k < TO && !done; k++) begin
        check({tag, ":req"}, dm_if.dm_req_o, 1'b1);
        check({tag, ":we"}, dm_if.dm_we_o, wr_en);
        check({tag, ":addr"}, dm_if.dm_addr_o, addr & 32'hFFFF_FFFC);
        check({tag, ":be"}, dm_if.dm_be_o, model_be(beop, addr));
        if (wr_en) check({tag, ":wdata"}, dm_if.dm_wdata_o, model_wdata(beop, rt));
        if (k == waits) begin
          dm_if.dm_ack_i   = 1'b1;
          dm_if.dm_rdata_i = rdata;
          #1;
          check({tag, ":stall_ack"}, stall, 1'b0);
          @(posedge clk); @(negedge clk);
          dm_if.dm_ack_i = 1'b0;
          check({tag, ":req_done"}, dm_if.dm_req_o, 1'b0);
          check({tag, ":sig_wb"}, signal_wb, sig);
          check({tag, ":npc_wb"}, npc_wb, npc);
          check({tag, ":alu_wb"}, alu_out_wb, addr);
          check({tag, ":rd_wb"}, rd_wb, rdf);
          check({tag, ":ld_wb"}, load_data_wb, wr_en ? 32'd0 : model_load(beop, addr, rdata));
          check({tag, ":err"}, mem_err, 1'b0);
          done = 1'b1;
        end else begin
          #1;
          check({tag, ":stall_req"}, stall, (k == TO - 1) ? 1'b0 : 1'b1);
          @(posedge clk); @(negedge clk);
        end
      end
      if (!done) begin
        check({tag, ":req_to"}, dm_if.dm_req_o, 1'b0);
        check({tag, ":err_to"}, mem_err, 1'b1);
        check({tag, ":sig_to"}, signal_wb, 32'd0);
      end
    end
    sig2 = $urandom;
    sig2[11:10] = 2'b00;
    signal_mem = sig2;
    dm_if.dm_ack_i   = 1'($urandom_range(0, 1));
    dm_if.dm_rdata_i = $urandom;
    #1;
    check({tag, ":stall_nop"}, stall, 1'b0);
    @(posedge clk); @(negedge clk);
    dm_if.dm_ack_i = 1'b0;
    check({tag, ":err_clr"}, mem_err, 1'b0);
    check({tag, ":req_nop"}, dm_if.dm_req_o, 1'b0);
    check({tag, ":sig_nop"}, signal_wb, sig2);
    check({tag, ":ld_nop"}, load_data_wb, 32'd0);
  endtask

  initial begin
    logic [2:0]  rb;
    int          rw, ws;
    rst = 1'b1;
    signal_mem = '0; npc_mem = '0; alu_out_mem = '0; rt_mem = '0; rd_mem = '0;
    dm_if.dm_ack_i = 1'b0;
    dm_if.dm_rdata_i = '0;
    @(negedge clk); @(negedge clk);
    check("rst:req", dm_if.dm_req_o, 1'b0);
    check("rst:stall", stall, 1'b0);
    check("rst:err", mem_err, 1'b0);
    check("rst:sig_wb", signal_wb, 32'd0);
    check("rst:npc_wb", npc_wb, 32'd0);
    check("rst:ld_wb", load_data_wb, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("sw",     3'd0, 1'b0, 1'b1, 32'h100, 32'h1122_3344, 32'h0, 0);
    do_op("lb",     3'd4, 1'b1, 1'b0, 32'h103, 32'h0, 32'h80FF_FFFF, 1);
    do_op("lbu",    3'd3, 1'b1, 1'b0, 32'h103, 32'h0, 32'h80FF_FFFF, 2);
    do_op("sh",     3'd1, 1'b0, 1'b1, 32'h102, 32'h0000_BEEF, 32'h0, 0);
    do_op("lh_mis", 3'd2, 1'b1, 1'b0, 32'h101, 32'h0, 32'h1234_5678, 0);
    do_op("lw_ws3", 3'd0, 1'b1, 1'b0, 32'h200, 32'h0, 32'hCAFE_F00D, 3);
    do_op("lw_to",  3'd0, 1'b1, 1'b0, 32'h204, 32'h0, 32'h0, 99);
    do_op("lh_hi",  3'd2, 1'b1, 1'b0, 32'h302, 32'h0, 32'h9ABC_0000, 0);

    // Asynchronous reset in the middle of an outstanding request.
    signal_mem = 32'h0000_0400; alu_out_mem = 32'h40;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("mid:req_before", dm_if.dm_req_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid:req", dm_if.dm_req_o, 1'b0);
    check("mid:stall", stall, 1'b0);
    check("mid:err", mem_err, 1'b0);
    check("mid:sig_wb", signal_wb, 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    signal_mem = 32'h0000_0001;
    dm_if.dm_ack_i = 1'b1;
    @(posedge clk); @(negedge clk);
    dm_if.dm_ack_i = 1'b0;
    check("mid:req_after", dm_if.dm_req_o, 1'b0);
    check("mid:stall_after", stall, 1'b0);
    check("mid:sig_after", signal_wb, 32'h0000_0001);

    for (int i = 0; i < 60; i++) begin
      rb = 3'($urandom_range(0, 7));
      rw = $urandom_range(0, 3);
      ws = ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, 4);
      do_op("rnd", rb, rw[0], rw[1], $urandom, $urandom, $urandom, ws);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
